// File: rtl/display_content_arbiter.sv
// Fixed-priority display source arbiter: converts the winning numeric value to packed BCD
// with a sequential double-dabble engine and holds committed content (with blink) for the 7-seg driver.
module display_content_arbiter #(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DIGITS     = 8,
    parameter int unsigned BLINK_HALF = 25_000_000,
    parameter int unsigned SRC_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [NUM_SRC*2-1:0]      src_mode,
    input  logic [NUM_SRC-1:0]        src_blink,
    output logic [DIGITS*4-1:0]       disp_bcd,
    output logic [1:0]                disp_mode,
    output logic                      disp_blank,
    output logic [SRC_W-1:0]          disp_src,
    output logic                      disp_valid,
    output logic                      overflow,
    output logic                      busy
);

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned k = 0; k < n; k++) p = p * 64'd10;
        return p;
    endfunction

    localparam int unsigned BCD_W   = DIGITS * 4;
    localparam int unsigned CNT_W   = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int unsigned IT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [63:0] MAX_DEC = pow10(DIGITS) - 64'd1;

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;

    state_t                    state;
    logic                      tup_none;
    logic [SRC_W-1:0]          tup_idx;
    logic [DATA_W-1:0]         tup_data;
    logic                      tup_mode;
    logic                      tup_blink;
    logic [BCD_W-1:0]          acc;
    logic [DATA_W-1:0]         bin;
    logic [IT_W-1:0]           it;
    logic                      ovf_pend;
    logic                      blink_q;
    logic                      phase;
    logic [CNT_W-1:0]          blink_cnt;

    logic                      win_none;
    logic [SRC_W-1:0]          win_idx;
    logic [DATA_W-1:0]         win_data;
    logic                      win_mode;
    logic                      win_blink;
    logic                      win_big;
    logic                      change;
    logic                      blink_wrap;
    logic [BCD_W-1:0]          acc_adj;
    logic [BCD_W+DATA_W-1:0]   dd_next;

    // Lowest valid index wins; modes 2/3 collapse to character mode.
    always_comb begin
        win_none  = 1'b1;
        win_idx   = '0;
        win_data  = '0;
        win_mode  = 1'b0;
        win_blink = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_valid[i]) begin
                win_none  = 1'b0;
                win_idx   = SRC_W'(i);
                win_data  = src_data[i*DATA_W +: DATA_W];
                win_mode  = |src_mode[i*2 +: 2];
                win_blink = src_blink[i];
            end
        end
    end

    assign win_big = 64'(win_data) > MAX_DEC;

    // The latched tuple is also the last-committed reference, since detection only runs in S_IDLE.
    assign change = (win_none != tup_none) ||
                    (!win_none && ({win_idx, win_data, win_mode, win_blink} !=
                                   {tup_idx, tup_data, tup_mode, tup_blink}));

    assign blink_wrap = (blink_cnt == CNT_W'(BLINK_HALF - 1));

    // Double-dabble add-3 correction ahead of the shift.
    always_comb begin
        acc_adj = acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc[d*4 +: 4] >= 4'd5) acc_adj[d*4 +: 4] = acc[d*4 +: 4] + 4'd3;
        end
    end

    assign dd_next = {acc_adj, bin} << 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            tup_none   <= 1'b1;
            tup_idx    <= '0;
            tup_data   <= '0;
            tup_mode   <= 1'b0;
            tup_blink  <= 1'b0;
            acc        <= '0;
            bin        <= '0;
            it         <= '0;
            ovf_pend   <= 1'b0;
            blink_q    <= 1'b0;
            phase      <= 1'b0;
            blink_cnt  <= '0;
            disp_bcd   <= '0;
            disp_mode  <= 2'd0;
            disp_blank <= 1'b1;
            disp_src   <= '0;
            disp_valid <= 1'b0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if (blink_wrap) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + CNT_W'(1);
            end
            disp_blank <= ~disp_valid | (blink_q & (blink_wrap ? ~phase : phase));
            busy       <= (state == S_CONV);

            case (state)
                S_IDLE: begin
                    if (change) begin
                        tup_none  <= win_none;
                        tup_idx   <= win_idx;
                        tup_data  <= win_data;
                        tup_mode  <= win_mode;
                        tup_blink <= win_blink;
                        bin       <= win_data;
                        it        <= '0;
                        ovf_pend  <= 1'b0;
                        if (win_none) begin
                            acc   <= '0;
                            state <= S_COMMIT;
                        end else if (win_mode) begin
                            acc   <= BCD_W'(win_data);
                            state <= S_COMMIT;
                        end else if (win_big) begin
                            acc      <= {DIGITS{4'h9}};
                            ovf_pend <= 1'b1;
                            state    <= S_COMMIT;
                        end else begin
                            acc   <= '0;
                            state <= S_CONV;
                        end
                    end
                end
                S_CONV: begin
                    acc <= dd_next[BCD_W+DATA_W-1:DATA_W];
                    bin <= dd_next[DATA_W-1:0];
                    it  <= it + IT_W'(1);
                    if (it == IT_W'(DATA_W - 1)) state <= S_COMMIT;
                end
                S_COMMIT: begin
                    disp_bcd   <= acc;
                    disp_valid <= ~tup_none;
                    overflow   <= ovf_pend;
                    blink_q    <= tup_blink & ~tup_none;
                    disp_blank <= tup_none;
                    blink_cnt  <= '0;
                    phase      <= 1'b0;
                    if (!tup_none) begin
                        disp_src  <= tup_idx;
                        disp_mode <= {1'b0, tup_mode};
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_display_content_arbiter.sv
// Bench for display_content_arbiter: directed vector table, hand-written multi-cycle
// sequences (priority/non-abort, blink, reset) and random traffic against a decimal model.
module tb_display_content_arbiter;

    localparam int DW = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   src_valid;
    logic [127:0] src_data;
    logic [7:0]   src_mode;
    logic [3:0]   src_blink;
    logic [31:0]  disp_bcd;
    logic [1:0]   disp_mode;
    logic         disp_blank;
    logic [1:0]   disp_src;
    logic         disp_valid;
    logic         overflow;
    logic         busy;

    display_content_arbiter #(
        .NUM_SRC(4), .DATA_W(DW), .DIGITS(8), .BLINK_HALF(4), .SRC_W(2)
    ) dut (
        .clk(clk), .rst(rst),
        .src_valid(src_valid), .src_data(src_data), .src_mode(src_mode), .src_blink(src_blink),
        .disp_bcd(disp_bcd), .disp_mode(disp_mode), .disp_blank(disp_blank), .disp_src(disp_src),
        .disp_valid(disp_valid), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [3:0]   valid;
        logic [127:0] data;
        logic [7:0]   mode;
        logic [31:0]  bcd;
        logic [1:0]   emode;
        logic [1:0]   src;
        logic         vld;
        logic         ovf;
        int           lat;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Steps from just before the detection edge E to just after E+lat, checking hold and busy length.
    task automatic wait_commit(input int lat, input logic [31:0] pre_bcd, input logic pre_vld,
                               input string tag);
        int bc;
        bc = 0;
        for (int k = 0; k <= lat; k++) begin
            tick();
            if (busy === 1'b1) bc++;
            if (k == lat - 1) check({tag, "_hold"}, {31'd0, pre_vld, pre_bcd}, {31'd0, disp_valid, disp_bcd});
        end
        check({tag, "_busy_cycles"}, 64'(bc), (lat > 1) ? 64'(DW) : 64'd0);
        check({tag, "_busy_end"}, {63'd0, busy}, 64'd0);
    endtask

    function automatic logic [31:0] to_bcd(input logic [31:0] v);
        logic [31:0] r;
        int unsigned t;
        r = '0;
        t = v;
        for (int d = 0; d < 8; d++) begin
            r[d*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Reference model state: last committed tuple and expected outputs.
    logic        m_none, m_mode, m_blink;
    logic [1:0]  m_idx;
    logic [31:0] m_data;
    logic [31:0] e_bcd;
    logic [1:0]  e_mode, e_src;
    logic        e_vld, e_ovf;

    initial begin
        logic [31:0] prev_bcd;
        logic        prev_vld;

        tbl[0] = '{4'b0100, {32'd0, 32'd1234, 32'd0, 32'd0}, 8'h00, 32'h00001234, 2'd0, 2'd2, 1'b1, 1'b0, 33};
        tbl[1] = '{4'b0001, {96'd0, 32'h00000003}, 8'h01, 32'h00000003, 2'd1, 2'd0, 1'b1, 1'b0, 1};
        tbl[2] = '{4'b0001, {96'd0, 32'd100000000}, 8'h00, 32'h99999999, 2'd0, 2'd0, 1'b1, 1'b1, 1};
        tbl[3] = '{4'b0001, {96'd0, 32'd99999999}, 8'h00, 32'h99999999, 2'd0, 2'd0, 1'b1, 1'b0, 33};
        tbl[4] = '{4'b0000, 128'd0, 8'h00, 32'h00000000, 2'd0, 2'd0, 1'b0, 1'b0, 1};
        tbl[5] = '{4'b0001, 128'd0, 8'h00, 32'h00000000, 2'd0, 2'd0, 1'b1, 1'b0, 33};
        tbl[6] = '{4'b1010, {32'd55, 32'd0, 32'd7, 32'd0}, 8'h00, 32'h00000007, 2'd0, 2'd1, 1'b1, 1'b0, 33};
        tbl[7] = '{4'b1000, {32'hDEADBEEF, 96'd0}, 8'b1100_0000, 32'hDEADBEEF, 2'd1, 2'd3, 1'b1, 1'b0, 1};
        tbl[8] = '{4'b0000, 128'd0, 8'h00, 32'h00000000, 2'd0, 2'd3, 1'b0, 1'b0, 1};

        rst = 1'b1; src_valid = '0; src_data = '0; src_mode = '0; src_blink = '0;
        tick(); tick();
        check("rst_bcd", 64'(disp_bcd), 64'd0);
        check("rst_mode", 64'(disp_mode), 64'd0);
        check("rst_blank", 64'(disp_blank), 64'd1);
        check("rst_src", 64'(disp_src), 64'd0);
        check("rst_valid", 64'(disp_valid), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        tick(); tick();
        check("idle_none_no_commit", 64'(disp_valid), 64'd0);

        prev_bcd = '0;
        prev_vld = 1'b0;
        for (int v = 0; v < 9; v++) begin
            src_valid = tbl[v].valid;
            src_data  = tbl[v].data;
            src_mode  = tbl[v].mode;
            src_blink = '0;
            wait_commit(tbl[v].lat, prev_bcd, prev_vld, $sformatf("vec%0d", v));
            check($sformatf("vec%0d_bcd", v), 64'(disp_bcd), 64'(tbl[v].bcd));
            check($sformatf("vec%0d_valid", v), 64'(disp_valid), 64'(tbl[v].vld));
            check($sformatf("vec%0d_src", v), 64'(disp_src), 64'(tbl[v].src));
            check($sformatf("vec%0d_ovf", v), 64'(overflow), 64'(tbl[v].ovf));
            check($sformatf("vec%0d_blank", v), 64'(disp_blank), 64'(!tbl[v].vld));
            if (tbl[v].vld) check($sformatf("vec%0d_mode", v), 64'(disp_mode), 64'(tbl[v].emode));
            prev_bcd = tbl[v].bcd;
            prev_vld = tbl[v].vld;
            tick(); tick();
        end

        // Priority change mid-conversion does not abort; it is picked up after the commit.
        src_valid = 4'b1000;
        src_data  = {32'd99, 96'd0};
        src_mode  = '0;
        repeat (6) tick();
        src_valid = 4'b1010;
        src_data[63:32] = 32'd7;
        repeat (28) tick();
        check("prio_first_bcd", 64'(disp_bcd), 64'h99);
        check("prio_first_src", 64'(disp_src), 64'd3);
        check("prio_first_valid", 64'(disp_valid), 64'd1);
        repeat (33) tick();
        check("prio_hold_bcd", 64'(disp_bcd), 64'h99);
        tick();
        check("prio_second_bcd", 64'(disp_bcd), 64'h7);
        check("prio_second_src", 64'(disp_src), 64'd1);
        tick();

        // Blink: 4 visible, 4 blank, restarting visible on each commit.
        src_valid = 4'b0001;
        src_data  = {96'd0, 32'd5};
        src_mode  = 8'h01;
        src_blink = 4'b0001;
        tick(); tick();
        check("blink_bcd", 64'(disp_bcd), 64'h5);
        for (int k = 0; k < 14; k++) begin
            if (k > 0) tick();
            check($sformatf("blink_k%0d", k), 64'(disp_blank), 64'((k / 4) % 2));
        end
        src_data[31:0] = 32'd6;
        tick();
        check("blink_pre_restart", 64'(disp_blank), 64'd1);
        tick();
        check("blink_restart_bcd", 64'(disp_bcd), 64'h6);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) tick();
            check($sformatf("blink_r%0d", k), 64'(disp_blank), 64'((k / 4) % 2));
        end

        // Reset during conversion, then re-trigger from the still-valid source.
        src_valid = 4'b0001;
        src_data  = {96'd0, 32'd4321};
        src_mode  = '0;
        src_blink = '0;
        repeat (11) tick();
        check("conv_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        check("midrst_bcd", 64'(disp_bcd), 64'd0);
        check("midrst_blank", 64'(disp_blank), 64'd1);
        check("midrst_valid", 64'(disp_valid), 64'd0);
        check("midrst_src", 64'(disp_src), 64'd0);
        check("midrst_mode", 64'(disp_mode), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        wait_commit(33, 32'd0, 1'b0, "retrig");
        check("retrig_bcd", 64'(disp_bcd), 64'h4321);
        check("retrig_valid", 64'(disp_valid), 64'd1);

        m_none = 1'b0; m_idx = 2'd0; m_data = 32'd4321; m_mode = 1'b0; m_blink = 1'b0;
        e_bcd = 32'h4321; e_mode = 2'd0; e_src = 2'd0; e_vld = 1'b1; e_ovf = 1'b0;
        tick();

        for (int it = 0; it < 40; it++) begin
            logic        w_none, w_mode, changed;
            logic [1:0]  w_idx;
            logic [31:0] w_data;
            int          lat;
            logic [31:0] p_bcd;
            logic        p_vld;
            if ($urandom_range(0, 7) != 0) begin
                src_valid = 4'($urandom_range(0, 15));
                for (int s = 0; s < 4; s++) begin
                    case ($urandom_range(0, 3))
                        0: src_data[s*32 +: 32] = 32'($urandom_range(0, 9999));
                        1: src_data[s*32 +: 32] = 32'd99999998 + 32'($urandom_range(0, 2));
                        2: src_data[s*32 +: 32] = $urandom();
                        default: src_data[s*32 +: 32] = 32'($urandom_range(0, 99999999));
                    endcase
                    src_mode[s*2 +: 2] = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
                end
            end
            w_none = 1'b1; w_idx = 2'd0; w_data = '0; w_mode = 1'b0;
            for (int s = 3; s >= 0; s--) begin
                if (src_valid[s]) begin
                    w_none = 1'b0;
                    w_idx  = 2'(s);
                    w_data = src_data[s*32 +: 32];
                    w_mode = (src_mode[s*2 +: 2] != 2'd0);
                end
            end
            changed = (w_none != m_none) ||
                      (!w_none && (w_idx != m_idx || w_data != m_data || w_mode != m_mode || m_blink));
            p_bcd = e_bcd;
            p_vld = e_vld;
            lat = 1;
            if (changed) begin
                m_none = w_none; m_idx = w_idx; m_data = w_data; m_mode = w_mode; m_blink = 1'b0;
                e_ovf = 1'b0;
                if (w_none) begin
                    e_bcd = '0; e_vld = 1'b0;
                end else begin
                    e_vld = 1'b1; e_src = w_idx; e_mode = {1'b0, w_mode};
                    if (w_mode) e_bcd = w_data;
                    else if (w_data > 32'd99999999) begin e_bcd = 32'h99999999; e_ovf = 1'b1; end
                    else begin e_bcd = to_bcd(w_data); lat = 33; end
                end
                wait_commit(lat, p_bcd, p_vld, $sformatf("rnd%0d", it));
            end else begin
                repeat (3) tick();
            end
            check($sformatf("rnd%0d_bcd", it), 64'(disp_bcd), 64'(e_bcd));
            check($sformatf("rnd%0d_valid", it), 64'(disp_valid), 64'(e_vld));
            check($sformatf("rnd%0d_src", it), 64'(disp_src), 64'(e_src));
            check($sformatf("rnd%0d_ovf", it), 64'(overflow), 64'(e_ovf));
            check($sformatf("rnd%0d_blank", it), 64'(disp_blank), 64'(!e_vld));
            if (e_vld) check($sformatf("rnd%0d_mode", it), 64'(disp_mode), 64'(e_mode));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/display_content_arbiter.md
# display_content_arbiter

Parametrised successor to the state-driven display data mux. It arbitrates among NUM_SRC display requesters (timer, calculator, FSM op-select and others) by fixed priority. Numeric values are converted to packed BCD with a sequential double-dabble engine, and the committed content is held stable for the seven-segment driver with optional blinking. It sits between the control/datapath blocks and the seven-segment driver, which consumes `disp_bcd`/`disp_mode`/`disp_blank` directly.

## Interface
- `NUM_SRC`, 4: number of requesting sources; index 0 has the highest priority.
- `DATA_W`, 32: width of each source value.
- `DIGITS`, 8: display digits; `disp_bcd` is DIGITS*4 bits wide.
- `BLINK_HALF`, 25_000_000: clock cycles per blink half-period.
- `SRC_W`, $clog2(NUM_SRC) (min 1): width of the source index.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `src_valid`  in  NUM_SRC  per-source request.
- `src_data`  in  NUM_SRC*DATA_W  source i occupies bits [i*DATA_W +: DATA_W].
- `src_mode`  in  NUM_SRC*2  per-source mode: 0 = numeric, 1 = character code; 2 and 3 are treated as 1.
- `src_blink`  in  NUM_SRC  per-source blink enable.
- `disp_bcd`  out  DIGITS*4  committed digits; for character mode this is the raw low DIGITS*4 bits.
- `disp_mode`  out  2  committed mode.
- `disp_blank`  out  1  driver must blank all digits when high.
- `disp_src`  out  SRC_W  index of the committed source.
- `disp_valid`  out  1  committed content exists.
- `overflow`  out  1  committed numeric value was saturated.
- `busy`  out  1  conversion in progress.

## Operation
- Winner: the lowest index i with `src_valid[i]`=1. If no source is valid, the target is "none".
- Change detection runs in S_IDLE only. The winner's {index, data, mode, blink} is compared against the last committed tuple. A mismatch, or valid→none / none→valid, starts an update.
- States:
  - S_IDLE: on a change, latch the tuple.
    - Target none: go to S_COMMIT with blank content.
    - Mode≠0: go to S_COMMIT with pass-through.
    - Numeric and value > 10^DIGITS−1: go to S_COMMIT with all digits 9 and `overflow`=1.
    - Otherwise: clear the BCD accumulator and go to S_CONV.
  - S_CONV: one double-dabble iteration per cycle, MSB first. Any BCD nibble ≥5 gets +3, then the combined register shifts left by 1. After exactly DATA_W iterations, go to S_COMMIT.
  - S_COMMIT: write all `disp_*` outputs and `overflow` atomically, update the stored tuple, reset the blink phase to visible, and return to S_IDLE.
- Source changes during S_CONV/S_COMMIT are not aborting. They are re-evaluated in the first S_IDLE cycle after the commit, and intermediate values are dropped.
- Target none commits `disp_valid`=0, `disp_blank`=1, `disp_bcd`=0 and `overflow`=0; `disp_src` holds its previous value.
- Blink uses a free-running counter 0..BLINK_HALF−1. `phase` toggles on wrap.
  - `disp_blank` = ~`disp_valid` | (committed blink & `phase`).
  - A commit clears the counter and `phase`.
- `busy` = 1 exactly while in S_CONV.

## Timing
- Reset (applied at the next clk edge with `rst`=1): state S_IDLE, `disp_bcd`=0, `disp_mode`=0, `disp_blank`=1, `disp_src`=0, `disp_valid`=0, `overflow`=0, `busy`=0, blink counter and `phase` = 0, stored tuple = none.
- `rst` mid-conversion discards the conversion. The next S_IDLE cycle re-detects any valid source as a change.
- Inputs are stable before edge E, and S_IDLE detects the change at E.
  - Numeric path: `busy`=1 after edges E+1..E+DATA_W; outputs update at edge E+DATA_W+1 (33 for DATA_W=32).
  - Character, overflow or none: outputs update at edge E+1.
- Outputs never change outside S_COMMIT, except `disp_blank` via blink.
- Back-to-back updates: the minimum spacing between commits is DATA_W+2 cycles on the numeric path and 2 cycles otherwise.

## Test plan
- Numeric conversion: `src_valid`=4'b0100, source 2 = 32'd1234, mode 0. Expect `busy` high for 32 cycles, then `disp_bcd`=32'h00001234, `disp_src`=2, `disp_valid`=1 and `overflow`=0, 33 edges after detection.
- Character pass-through: source 0 = 32'h00000003, mode 1. Expect `disp_bcd`=32'h00000003 and `disp_mode`=1 one edge after detection, with `busy` never asserted.
- Priority and non-abort: source 3 numeric 32'd99 is converting; assert source 1 = 32'd7 at conversion cycle 5. Expect a commit of 32'h00000099/src 3 first, then 32'h00000007/src 1 after a further 33 edges.
- Overflow saturation: value 32'd100000000. Expect `disp_bcd`=32'h99999999 and `overflow`=1 at E+1. Then value 32'd99999999 gives `overflow`=0 and 32'h99999999 after the numeric latency.
- Blink: with BLINK_HALF=4 and `src_blink`=1, `disp_blank` must toggle every 4 cycles, starting visible at the commit. Committing new content restarts the phase visible.
- Reset and none: deassert all `src_valid` and expect `disp_valid`=0 and `disp_blank`=1 at E+1. Assert `rst` during S_CONV and expect all reset values next edge. After `rst` drops, a valid source re-triggers the conversion.
